// File: rtl/divider_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divider_seq_pkg
// Description : Shared ALU definitions for the sequential divider: FSM state
//               encoding and counter sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package divider_seq_pkg;

    // Divider control states; encodings are shared with other ALU blocks.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Bits needed for a counter that must hold the value n itself.
    function automatic int count_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage : divider_seq_pkg
`default_nettype wire

// File: rtl/divider_seq_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : SUBTRACTOR_N_BIT
// Description : Ripple-carry subtractor, out = in_a - in_b. cout is the
//               carry-out of in_a + ~in_b + 1, i.e. 1 when no borrow
//               occurred (in_a >= in_b, unsigned). overflow flags a signed
//               two's-complement overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module SUBTRACTOR_N_BIT #(
    parameter int size = 4
) (
    input  logic [size-1:0] in_a,
    input  logic [size-1:0] in_b,
    output logic [size-1:0] out,
    output logic            cout,
    output logic            overflow
);

    // Carry chain; the initial carry of 1 completes the two's complement of in_b.
    logic [size:0] w_carry;

    assign w_carry[0] = 1'b1;

    generate
        for (genvar i = 0; i < size; i++) begin : g_bit
            assign out[i]         = in_a[i] ^ ~in_b[i] ^ w_carry[i];
            assign w_carry[i + 1] = (in_a[i] & ~in_b[i]) |
                                    (in_a[i] & w_carry[i]) |
                                    (~in_b[i] & w_carry[i]);
        end
    endgenerate

    assign cout     = w_carry[size];
    assign overflow = w_carry[size] ^ w_carry[size-1];

endmodule : SUBTRACTOR_N_BIT
`default_nettype wire

// File: rtl/divider_seq.sv
`default_nettype none
// ============================================================================
// Module      : divider_seq
// Description : Multi-cycle unsigned restoring divider, one quotient bit per
//               clock. A zero divisor short-circuits straight to DONE with
//               quotient = all ones, remainder = dividend, div_by_zero = 1.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_seq
    import divider_seq_pkg::*;
#(
    parameter int size = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [size-1:0] dividend,
    input  logic [size-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [size-1:0] quotient,
    output logic [size-1:0] remainder,
    output logic            div_by_zero
);

    localparam int CW = count_width(size);

    // Control state and iteration counter
    div_state_t      state_q, state_d;
    logic [CW-1:0]   count_q, count_d;

    // Datapath: partial remainder, shifting dividend/quotient, latched divisor
    logic [size:0]   p_q, p_d;
    logic [size-1:0] q_q, q_d;
    logic [size-1:0] d_q, d_d;

    // Result registers, held until the next accepted start
    logic [size-1:0] quo_q, quo_d;
    logic [size-1:0] rem_q, rem_d;
    logic            dbz_q, dbz_d;

    // Subtractor interface
    logic [size:0]   w_shifted;
    logic [size:0]   w_diff;
    logic            w_no_borrow;

    // Bring the next dividend bit into the partial remainder.
    assign w_shifted = {p_q[size-1:0], q_q[size-1]};

    // Divisor is never zero while RUN, so cout is a true "s >= divisor" flag.
    SUBTRACTOR_N_BIT #(
        .size (size + 1)
    ) u_sub (
        .in_a     (w_shifted),
        .in_b     ({1'b0, d_q}),
        .out      (w_diff),
        .cout     (w_no_borrow),
        .overflow ()
    );

    // Next-state, datapath and result update logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        p_d     = p_q;
        q_d     = q_q;
        d_d     = d_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (start) begin
                    if (divisor != '0) begin
                        d_d     = divisor;
                        q_d     = dividend;
                        p_d     = '0;
                        count_d = CW'(size);
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end else begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end

            RUN: begin
                // Restoring step: keep the difference only if it did not borrow.
                p_d     = w_no_borrow ? w_diff : w_shifted;
                q_d     = {q_q[size-2:0], w_no_borrow};
                count_d = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    state_d = DONE;
                    quo_d   = q_d;
                    rem_d   = p_d[size-1:0];
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous abort on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            p_q     <= p_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule : divider_seq
`default_nettype wire

// File: tb/tb_divider_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_seq
// Description : Self-checking bench for divider_seq (size = 4). Results are
//               compared with plain-arithmetic division in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_seq;

    localparam int SIZE = 4;
    localparam int MAXW = 20;

    logic            clk;
    logic            rst;
    logic            start;
    logic [SIZE-1:0] dividend;
    logic [SIZE-1:0] divisor;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] quotient;
    logic [SIZE-1:0] remainder;
    logic            div_by_zero;

    int tests = 0;
    int fails = 0;

    divider_seq #(
        .size (SIZE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: ordinary integer division, zero divisor gives all-ones/dividend.
    task automatic model(input int a, input int b, output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << SIZE) - 1;
            r = a;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endtask

    // Called at the first negedge after the accepting edge: waits for done,
    // checks busy duration, results and that done is a single-cycle pulse.
    task automatic wait_and_check(input string tag, input int a, input int b, input bit full);
        int q, r, z, nbusy, n;
        model(a, b, q, r, z);
        nbusy = 0;
        n     = 0;
        while (done !== 1'b1 && n < MAXW) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            n++;
        end
        check({tag, " done seen"}, {31'd0, done}, 32'd1);
        if (full) begin
            check({tag, " busy cycles"}, nbusy, (b == 0) ? 0 : SIZE);
            check({tag, " busy low at done"}, {31'd0, busy}, 32'd0);
            check({tag, " dbz"}, {31'd0, div_by_zero}, z);
        end
        check({tag, " quotient"}, quotient, q);
        check({tag, " remainder"}, remainder, r);
        if (b != 0) begin
            check({tag, " invariant"}, quotient * b + remainder, a);
        end
        if (full) begin
            @(negedge clk);
            check({tag, " done pulse one cycle"}, {31'd0, done}, 32'd0);
        end
    endtask

    task automatic launch(input int a, input int b);
        @(negedge clk);
        dividend = SIZE'(a);
        divisor  = SIZE'(b);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic run_div(input string tag, input int a, input int b, input bit full);
        launch(a, b);
        wait_and_check(tag, a, b, full);
    endtask

    initial begin
        int a, b, held_q, held_r;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state
        #3;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: basic 13/3
        run_div("t1 13/3", 13, 3, 1'b1);

        // 2: boundaries and exhaustive sweep
        run_div("t2 15/1", 15, 1, 1'b1);
        run_div("t2 5/7", 5, 7, 1'b1);
        run_div("t2 15/15", 15, 15, 1'b1);
        run_div("t2 0/4", 0, 4, 1'b1);
        for (int x = 0; x < 16; x++) begin
            for (int y = 1; y < 16; y++) begin
                run_div("t2 sweep", x, y, 1'b0);
            end
        end

        // 3: divide by zero, then a normal division clears the flag
        run_div("t3 9/0", 9, 0, 1'b1);
        run_div("t3 8/2", 8, 2, 1'b1);

        // 4: start during RUN is ignored; results hold after done
        launch(13, 3);
        dividend = 4'd6;
        divisor  = 4'd2;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_and_check("t4 13/3 ignore", 13, 3, 1'b0);
        held_q = quotient;
        held_r = remainder;
        repeat (3) @(negedge clk);
        check("t4 hold busy", {31'd0, busy}, 32'd0);
        check("t4 hold quotient", quotient, 32'd4);
        check("t4 hold remainder", remainder, 32'd1);
        check("t4 hold vs done q", quotient, held_q);
        check("t4 hold vs done r", remainder, held_r);

        // 5: back-to-back start on the done cycle
        launch(13, 3);
        wait_and_check("t5 first 13/3", 13, 3, 1'b0);
        dividend = 4'd14;
        divisor  = 4'd4;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        check("t5 busy immediately", {31'd0, busy}, 32'd1);
        wait_and_check("t5 14/4", 14, 4, 1'b1);

        // 6: asynchronous reset mid-RUN
        launch(13, 3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6 rst busy", {31'd0, busy}, 32'd0);
        check("t6 rst done", {31'd0, done}, 32'd0);
        check("t6 rst quotient", quotient, 32'd0);
        check("t6 rst remainder", remainder, 32'd0);
        check("t6 rst dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div("t6 7/2", 7, 2, 1'b1);
        // Reset must also clear a set div_by_zero flag
        run_div("t6 3/0", 3, 0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t6 rst dbz after zero", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Random divisions including occasional zero divisors
        for (int k = 0; k < 40; k++) begin
            a = int'($urandom_range(15, 0));
            b = int'($urandom_range(15, 0));
            run_div("rand", a, b, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_divider_seq
`default_nettype wire
